multi_debounce: RTL and testbench

N_CH-channel switch debouncer with one shared tick prescaler and an independent per-channel confirm FSM.
- Each channel's filtered level db changes only after its input has held the new level for STABLE_TICKS consecutive prescaler ticks.
- Each accepted change also produces a one-cycle rise or fall pulse.
- Sits between board switch/button pins and the control logic; replaces ad-hoc single-channel debouncers.

---
 rtl/multi_debounce.sv | 145 ++++++++++++++
 tb/tb_multi_debounce.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// Multi-channel switch debouncer: shared tick prescaler, per-channel confirm FSM.
// Optional 2-flop input synchronizer enabled by defining DEBOUNCE_SYNC_EN.
module multi_debounce #(
   parameter int unsigned N_CH         = 4,
   parameter int unsigned TICK_DIV     = 10,
   parameter int unsigned STABLE_TICKS = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] sw,
   output logic [N_CH-1:0] db,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            tick
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
   localparam logic [PW-1:0] PreLast = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CntLast = CW'(STABLE_TICKS - 1);

   typedef enum logic [1:0] {StS0, StW1, StS1, StW0} state_e;

   logic [PW-1:0]   pre_q, pre_d;
   logic [N_CH-1:0] s;
   state_e          state_q [N_CH];
   state_e          state_d [N_CH];
   logic [CW-1:0]   cnt_q   [N_CH];
   logic [CW-1:0]   cnt_d   [N_CH];
   logic [N_CH-1:0] db_d, rise_d, fall_d;

   assign tick  = (pre_q == PreLast);
   assign pre_d = tick ? '0 : pre_q + PW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
   end

`ifdef DEBOUNCE_SYNC_EN
   logic [N_CH-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = sw;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= StS0;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Next state: a reversal in W1/W0 wins over a simultaneous tick
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            StS0: begin
               if (s[i]) begin
                  state_d[i] = StW1;
                  cnt_d[i]   = '0;
               end
            end
            StW1: begin
               if (!s[i]) begin
                  state_d[i] = StS0;
                  cnt_d[i]   = '0;
               end else if (tick) begin
                  if (cnt_q[i] == CntLast) begin
                     state_d[i] = StS1;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end
               end
            end
            StS1: begin
               if (!s[i]) begin
                  state_d[i] = StW0;
                  cnt_d[i]   = '0;
               end
            end
            StW0: begin
               if (s[i]) begin
                  state_d[i] = StS1;
                  cnt_d[i]   = '0;
               end else if (tick) begin
                  if (cnt_q[i] == CntLast) begin
                     state_d[i] = StS0;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end
               end
            end
         endcase
      end
   end

   // Outputs, registered so they change on the acceptance edge
   always_comb begin
      db_d   = '0;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         db_d[i]   = (state_d[i] == StS1) || (state_d[i] == StW0);
         rise_d[i] = (state_q[i] == StW1) && (state_d[i] == StS1);
         fall_d[i] = (state_q[i] == StW0) && (state_d[i] == StS0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db   <= '0;
         rise <= '0;
         fall <= '0;
      end else begin
         db   <= db_d;
         rise <= rise_d;
         fall <= fall_d;
      end
   end

endmodule

// File: tb/tb_multi_debounce.sv
// Self-checking bench for multi_debounce: vector table, cycle scoreboard, corner sequences.
module tb_multi_debounce;

   localparam int unsigned N_CH         = 4;
   localparam int unsigned TICK_DIV     = 4;
   localparam int unsigned STABLE_TICKS = 3;
`ifdef DEBOUNCE_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N_CH-1:0] sw  = '0;
   logic [N_CH-1:0] db, rise, fall;
   logic            tick;

   always #5 clk = ~clk;

   multi_debounce #(
      .N_CH         (N_CH),
      .TICK_DIV     (TICK_DIV),
      .STABLE_TICKS (STABLE_TICKS)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .sw   (sw),
      .db   (db),
      .rise (rise),
      .fall (fall),
      .tick (tick)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending flag plus tick count per channel, compared with accepted level
   typedef struct packed {
      logic [N_CH-1:0] db;
      logic [N_CH-1:0] rise;
      logic [N_CH-1:0] fall;
      logic            tick;
   } exp_t;

   exp_t            exp_q[$];
   logic [N_CH-1:0] m_db, m_sy1, m_sy2;
   bit              m_pend [N_CH];
   int              m_cnt  [N_CH];
   int              m_pre;

   always @(posedge clk or posedge rst) begin : model
      logic [N_CH-1:0] ms, mr, mf;
      logic            mt;
      exp_t            e;
      if (rst) begin
         m_db  = '0;
         m_sy1 = '0;
         m_sy2 = '0;
         m_pre = 0;
         for (int i = 0; i < N_CH; i++) begin
            m_pend[i] = 1'b0;
            m_cnt[i]  = 0;
         end
         exp_q.delete();
      end else begin
         mt = (m_pre == TICK_DIV - 1);
`ifdef DEBOUNCE_SYNC_EN
         ms = m_sy2;
`else
         ms = sw;
`endif
         m_sy2 = m_sy1;
         m_sy1 = sw;
         mr = '0;
         mf = '0;
         for (int i = 0; i < N_CH; i++) begin
            if (!m_pend[i]) begin
               if (ms[i] != m_db[i]) begin
                  m_pend[i] = 1'b1;
                  m_cnt[i]  = 0;
               end
            end else if (ms[i] == m_db[i]) begin
               m_pend[i] = 1'b0;
            end else if (mt) begin
               if (m_cnt[i] == STABLE_TICKS - 1) begin
                  m_db[i]   = ms[i];
                  m_pend[i] = 1'b0;
                  if (ms[i]) mr[i] = 1'b1;
                  else       mf[i] = 1'b1;
               end else begin
                  m_cnt[i]++;
               end
            end
         end
         m_pre = mt ? 0 : m_pre + 1;
         e.db   = m_db;
         e.rise = mr;
         e.fall = mf;
         e.tick = (m_pre == TICK_DIV - 1);
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin : scoreboard
      exp_t e;
      if (!rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_db", db, e.db);
         check("sb_rise", rise, e.rise);
         check("sb_fall", fall, e.fall);
         check("sb_tick", tick, e.tick);
      end
   end

   typedef struct {
      string           name;
      logic [N_CH-1:0] sw;
      int              hold;
      logic [N_CH-1:0] db;
      logic [N_CH-1:0] rise;
      logic [N_CH-1:0] fall;
   } vec_t;

   vec_t vecs [11];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : main
      logic [N_CH-1:0] rise_acc, fall_acc;
      int n, lat;

      vecs[0]  = '{"press0",   4'b0001, 16, 4'b0001, 4'b0001, 4'b0000};
      vecs[1]  = '{"glitch1",  4'b0011,  2, 4'b0001, 4'b0000, 4'b0000};
      vecs[2]  = '{"abort1",   4'b0001, 16, 4'b0001, 4'b0000, 4'b0000};
      vecs[3]  = '{"wide1",    4'b0011,  8, 4'b0001, 4'b0000, 4'b0000};
      vecs[4]  = '{"release0", 4'b0000, 16, 4'b0000, 4'b0000, 4'b0001};
      vecs[5]  = '{"press2",   4'b0100, 16, 4'b0100, 4'b0100, 4'b0000};
      vecs[6]  = '{"release2", 4'b0000, 16, 4'b0000, 4'b0000, 4'b0100};
      vecs[7]  = '{"all",      4'b1111, 16, 4'b1111, 4'b1111, 4'b0000};
      vecs[8]  = '{"none",     4'b0000, 16, 4'b0000, 4'b0000, 4'b1111};
      vecs[9]  = '{"short",    4'b1010,  5, 4'b0000, 4'b0000, 4'b0000};
      vecs[10] = '{"quiet",    4'b0000, 16, 4'b0000, 4'b0000, 4'b0000};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_db", db, 0);
      check("reset_rise", rise, 0);
      check("reset_fall", fall, 0);
      check("reset_tick", tick, 0);
      #2 rst = 1'b0;

      @(posedge clk);
      #1;
      for (int v = 0; v < 11; v++) begin
         sw       = vecs[v].sw;
         rise_acc = '0;
         fall_acc = '0;
         for (int c = 0; c < vecs[v].hold; c++) begin
            @(posedge clk);
            #1;
            rise_acc |= rise;
            fall_acc |= fall;
         end
         check({vecs[v].name, "_db"}, db, vecs[v].db);
         check({vecs[v].name, "_rise"}, rise_acc, vecs[v].rise);
         check({vecs[v].name, "_fall"}, fall_acc, vecs[v].fall);
      end

      // Press latency, counted in edges after the edge that first samples sw
      sw = 4'b0001;
      n  = 0;
      while (n < 40 && db[0] !== 1'b1) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("lat_timeout", (n < 40), 1);
      lat = n - 1;
      check("lat_window", (lat >= 9 + SYNC_LAT && lat <= 12 + SYNC_LAT), 1);
      check("lat_rise", rise, 4'b0001);
      check("lat_fall", fall, 4'b0000);
      @(posedge clk);
      #1;
      check("lat_rise_1cyc", rise, 4'b0000);
      check("lat_others", db, 4'b0001);

      // Tick period
      n = 0;
      while (n < 20 && tick !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      check("tick_seen", (n < 20), 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (n < 20 && tick !== 1'b1);
      check("tick_period", n, TICK_DIV);

      // Reset during a pending confirm on channel 3
      @(posedge clk);
      #1;
      sw = 4'b1001;
      for (int k = 0; k < 2; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (n < 20 && tick !== 1'b1);
         check("rst_tick_wait", (n < 20), 1);
      end
      #2 rst = 1'b1;
      #1;
      check("rst_async_db", db, 0);
      check("rst_async_rise", rise, 0);
      check("rst_async_fall", fall, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("rst_no_early", db, 4'b0000);
      @(posedge clk);
      #1;
      check("rst_restart_db", db, 4'b1001);
      check("rst_restart_rise", rise, 4'b1001);
      repeat (4) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
